// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, NOP encoding and fetch FSM states
package riscv_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} fetch_state_t;
endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner issuing single-outstanding imem fetches toward the IF/ID register
module if_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] next_pc_i,
   input  logic            redirect_i,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [ILEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   input  logic            if_ready_i,
   output logic [XLEN-1:0] if_pc_o,
   output logic [ILEN-1:0] if_instr_o,
   output logic            misaligned_o
);
   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, if_pc_q, if_pc_d;
   logic [ILEN-1:0] if_instr_q, if_instr_d;
   logic            kill_q, kill_d, mis_q, mis_d, bad_tgt;
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      kill_d     = kill_q;
      mis_d      = mis_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      bad_tgt    = redirect_i && (next_pc_i[1:0] != 2'b00);
      if (redirect_i) begin
         mis_d = bad_tgt;
         pc_d  = bad_tgt ? pc_q : next_pc_i;
      end
      case (state_q)
         S_IDLE: state_d = mis_d ? S_IDLE : S_REQ;
         S_REQ: begin
            kill_d  = kill_q | redirect_i;
            state_d = imem_gnt_i ? S_WAIT : S_REQ;
         end
         S_WAIT:
            if (imem_rvalid_i) begin
               kill_d = 1'b0;
               if (kill_q || redirect_i) state_d = mis_d ? S_IDLE : S_REQ;
               else begin
                  if_pc_d    = pc_q;
                  if_instr_d = imem_rdata_i;
                  state_d    = S_HOLD;
               end
            end else kill_d = kill_q | redirect_i;
         S_HOLD:
            if (redirect_i) state_d = mis_d ? S_IDLE : S_REQ;
            else if (if_ready_i) begin
               pc_d    = next_pc_i;
               state_d = S_REQ;
            end
      endcase
      // the address is latched only on entry to S_REQ so a pending request never moves
      if (state_d == S_REQ && state_q != S_REQ) addr_d = pc_d;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         kill_q     <= 1'b0;
         mis_q      <= 1'b0;
         if_pc_q    <= RESET_PC;
         if_instr_q <= NOP_INSTR;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         kill_q     <= kill_d;
         mis_q      <= mis_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
      end
   end
   assign pc_plus4_o   = pc_q + XLEN'(4);
   assign imem_req_o   = state_q == S_REQ;
   assign imem_addr_o  = addr_q;
   assign if_valid_o   = state_q == S_HOLD;
   assign if_pc_o      = if_pc_q;
   assign if_instr_o   = if_instr_q;
   assign misaligned_o = mis_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vector table, wrap/reset sequence and randomized program-order check
module tb_if_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0, redirect_i = 1'b0, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0, if_ready_i = 1'b0;
   logic [63:0] next_pc_i = '0, pc_plus4_o, imem_addr_o, if_pc_o;
   logic [31:0] imem_rdata_i = '0, if_instr_o;
   logic        imem_req_o, if_valid_o, misaligned_o;
   logic        b_rst_n = 1'b0, b_gnt = 1'b0, b_rvalid = 1'b0;
   logic [31:0] b_rdata = '0, b_instr;
   logic [63:0] b_p4, b_addr, b_pc;
   logic        b_req, b_valid, b_mis;
   int n_vec = 0, n_bad = 0, n_del = 0;
   always #5 clk = ~clk;
   if_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .next_pc_i(next_pc_i), .redirect_i(redirect_i), .pc_plus4_o(pc_plus4_o),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .if_valid_o(if_valid_o),
      .if_ready_i(if_ready_i), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o), .misaligned_o(misaligned_o)
   );
   if_fetch_unit #(.RESET_PC(TOP)) dut_top (
      .clk(clk), .rst_n(b_rst_n), .next_pc_i(b_p4), .redirect_i(1'b0), .pc_plus4_o(b_p4),
      .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(b_gnt),
      .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata), .if_valid_o(b_valid),
      .if_ready_i(1'b0), .if_pc_o(b_pc), .if_instr_o(b_instr), .misaligned_o(b_mis)
   );
   typedef struct {
      logic r, d; logic [63:0] n; logic g, rv; logic [31:0] rdata; logic rdy;
      logic req; logic [63:0] addr; logic val; logic [63:0] pc; logic [31:0] instr; logic mis; logic [63:0] p4;
   } vec_t;
   vec_t tv[$];
   function automatic vec_t mk(input logic r, d, input logic [63:0] n, input logic g, rv,
                               input logic [31:0] rdata, input logic rdy, req, input logic [63:0] addr,
                               input logic val, input logic [63:0] pc, input logic [31:0] instr,
                               input logic mis, input logic [63:0] p4);
      vec_t v;
      v.r = r; v.d = d; v.n = n; v.g = g; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
      v.req = req; v.addr = addr; v.val = val; v.pc = pc; v.instr = instr; v.mis = mis; v.p4 = p4;
      return v;
   endfunction
   function automatic logic [31:0] mem(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   initial begin
      logic [63:0] exp_pc, prev_addr, tgt;
      logic [31:0] rsp;
      bit          outst, prev_stall, mis_exp;
      int          cnt;
      tv.push_back(mk(0,0,0,0,0,0,0, 0,64'h0,0,64'h0,NOP,0,64'h4));
      tv.push_back(mk(1,0,0,0,0,0,0, 0,64'h0,0,64'h0,NOP,0,64'h4));
      tv.push_back(mk(1,0,0,1,0,0,0, 1,64'h0,0,64'h0,NOP,0,64'h4));
      tv.push_back(mk(1,0,0,0,1,32'hA1A1_0001,0, 0,64'h0,0,64'h0,NOP,0,64'h4));
      for (int i = 0; i < 5; i++) tv.push_back(mk(1,0,0,0,0,0,0, 0,64'h0,1,64'h0,32'hA1A1_0001,0,64'h4));
      tv.push_back(mk(1,0,0,0,0,0,1, 0,64'h0,1,64'h0,32'hA1A1_0001,0,64'h4));
      tv.push_back(mk(1,0,0,0,0,0,0, 1,64'h4,0,64'h0,32'hA1A1_0001,0,64'h8));
      tv.push_back(mk(1,1,64'h100,0,0,0,0, 1,64'h4,0,64'h0,32'hA1A1_0001,0,64'h8));
      tv.push_back(mk(1,0,0,0,0,0,0, 1,64'h4,0,64'h0,32'hA1A1_0001,0,64'h104));
      tv.push_back(mk(1,0,0,0,0,0,0, 1,64'h4,0,64'h0,32'hA1A1_0001,0,64'h104));
      tv.push_back(mk(1,0,0,1,0,0,0, 1,64'h4,0,64'h0,32'hA1A1_0001,0,64'h104));
      tv.push_back(mk(1,0,0,0,1,32'hBAD0_0001,0, 0,64'h4,0,64'h0,32'hA1A1_0001,0,64'h104));
      tv.push_back(mk(1,0,0,1,0,0,0, 1,64'h100,0,64'h0,32'hA1A1_0001,0,64'h104));
      tv.push_back(mk(1,1,64'h200,0,1,32'hBAD0_0002,0, 0,64'h100,0,64'h0,32'hA1A1_0001,0,64'h104));
      tv.push_back(mk(1,0,0,1,0,0,0, 1,64'h200,0,64'h0,32'hA1A1_0001,0,64'h204));
      tv.push_back(mk(1,0,0,0,1,32'hC3C3_0003,0, 0,64'h200,0,64'h0,32'hA1A1_0001,0,64'h204));
      tv.push_back(mk(1,1,64'h102,0,0,0,1, 0,64'h200,1,64'h200,32'hC3C3_0003,0,64'h204));
      tv.push_back(mk(1,0,0,0,0,0,0, 0,64'h200,0,64'h200,32'hC3C3_0003,1,64'h204));
      tv.push_back(mk(1,0,0,0,0,0,0, 0,64'h200,0,64'h200,32'hC3C3_0003,1,64'h204));
      tv.push_back(mk(1,1,64'h300,0,0,0,0, 0,64'h200,0,64'h200,32'hC3C3_0003,1,64'h204));
      tv.push_back(mk(1,0,0,1,0,0,0, 1,64'h300,0,64'h200,32'hC3C3_0003,0,64'h304));
      tv.push_back(mk(1,0,0,0,1,32'hD4D4_0004,0, 0,64'h300,0,64'h200,32'hC3C3_0003,0,64'h304));
      tv.push_back(mk(1,0,0,0,0,0,1, 0,64'h300,1,64'h300,32'hD4D4_0004,0,64'h304));
      tv.push_back(mk(0,0,0,0,0,0,0, 1,64'h304,0,64'h300,32'hD4D4_0004,0,64'h308));
      tv.push_back(mk(1,0,0,0,0,0,0, 0,64'h0,0,64'h0,NOP,0,64'h4));
      repeat (2) @(posedge clk);
      foreach (tv[i]) begin
         #1;
         rst_n = tv[i].r; redirect_i = tv[i].d; imem_gnt_i = tv[i].g; imem_rvalid_i = tv[i].rv;
         imem_rdata_i = tv[i].rdata; if_ready_i = tv[i].rdy;
         next_pc_i = tv[i].d ? tv[i].n : pc_plus4_o;
         @(negedge clk);
         chk($sformatf("vec%0d", i),
             {imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, misaligned_o, pc_plus4_o},
             {tv[i].req, tv[i].addr, tv[i].val, tv[i].pc, tv[i].instr, tv[i].mis, tv[i].p4});
         @(posedge clk);
      end
      #1;
      rst_n = 1'b0; redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; if_ready_i = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_pc = '0; mis_exp = 1'b0; outst = 1'b0; cnt = 0; rsp = '0; prev_stall = 1'b0; prev_addr = '0;
      for (int c = 0; c < 3000; c++) begin
         #1;
         redirect_i = ($urandom % 16) == 0;
         tgt = {52'h0, 10'($urandom_range(0, 1023)), 2'b00};
         if (($urandom % 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
         imem_gnt_i    = imem_req_o && ($urandom % 2 == 1);
         imem_rvalid_i = outst && cnt == 0;
         imem_rdata_i  = imem_rvalid_i ? rsp : $urandom;
         if_ready_i    = ($urandom % 4) != 0;
         next_pc_i     = redirect_i ? tgt : pc_plus4_o;
         @(negedge clk);
         chk("misaligned", 256'(misaligned_o), 256'(mis_exp));
         if (imem_req_o) chk("one_outstanding", 256'(outst), 256'(0));
         if (prev_stall) chk("addr_stable", {imem_req_o, imem_addr_o}, {1'b1, prev_addr});
         if (if_valid_o && if_ready_i && !redirect_i) begin
            chk("deliver", {if_pc_o, if_instr_o}, {exp_pc, mem(exp_pc)});
            exp_pc = exp_pc + 64'd4;
            n_del++;
         end
         if (redirect_i) begin
            mis_exp = tgt[1:0] != 2'b00;
            if (!mis_exp) exp_pc = tgt;
         end
         if (imem_rvalid_i) outst = 1'b0;
         else if (outst) cnt--;
         if (imem_req_o && imem_gnt_i) begin
            outst = 1'b1; cnt = $urandom_range(0, 3); rsp = mem(imem_addr_o);
         end
         prev_stall = imem_req_o && !imem_gnt_i;
         prev_addr  = imem_addr_o;
         @(posedge clk);
      end
      chk("progress", 256'(n_del > 50), 256'(1));
      #1;
      @(negedge clk);
      chk("wrap_reset", {b_p4, b_addr, b_pc, b_instr, b_req, b_valid, b_mis}, {64'h0, TOP, TOP, NOP, 3'b000});
      @(posedge clk);
      #1 b_rst_n = 1'b1;
      @(posedge clk);
      #1 b_gnt = 1'b1;
      @(negedge clk);
      chk("wrap_req", {b_req, b_addr, b_p4}, {1'b1, TOP, 64'h0});
      @(posedge clk);
      #1 b_gnt = 1'b0; b_rst_n = 1'b0;
      @(negedge clk);
      chk("wrap_wait", {b_req, b_valid}, 2'b00);
      @(posedge clk);
      #1 b_rst_n = 1'b1; b_rvalid = 1'b1; b_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("reset_mid_fetch", {b_p4, b_addr, b_pc, b_instr, b_req, b_valid, b_mis}, {64'h0, TOP, TOP, NOP, 3'b000});
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stray_rvalid", {b_valid, b_req, b_addr, b_pc, b_instr}, {2'b01, TOP, TOP, NOP});
      @(posedge clk);
      #1 b_rvalid = 1'b0;
      @(negedge clk);
      chk("stray_rvalid_after", {b_valid, b_req, b_instr}, {2'b01, NOP});
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
